// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding and sizing constants for the 3x3 convolution sequencer
package conv_pkg;
  typedef enum logic [2:0] {IDLE, COL0, COL1, COL2, DONE} state_t;
  localparam int PIX_W     = 8;
  localparam int TAPS      = 9;
  localparam int COL_SUM_W = 16;
  localparam int ACC_W_MIN = 18;
endpackage

// File: rtl/comp.sv
// comp: column-multiplexed 3x3 MAC, sums img*kern over the three rows of column select, modulo 2^16
module comp import conv_pkg::*; (
  input  logic [1:0]           select,
  input  logic [PIX_W-1:0]     img  [TAPS],
  input  logic [PIX_W-1:0]     kern [TAPS],
  output logic [COL_SUM_W-1:0] sum16
);
  logic [3:0]           idx  [3];
  logic [COL_SUM_W-1:0] prod [3];
  for (genvar r = 0; r < 3; r++) begin : g_row
    assign idx[r]  = 4'(3 * r) + {2'b00, select};
    assign prod[r] = (select == 2'd3) ? '0 : img[idx[r]] * kern[idx[r]];
  end
  assign sum16 = prod[0] + prod[1] + prod[2];
endmodule

// File: rtl/conv3x3_sequencer.sv
// conv3x3_sequencer: latches kernel and window, steps comp through columns 0..2 and accumulates the column sums
module conv3x3_sequencer import conv_pkg::*; #(
  parameter int ACC_W = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   kernel_load,
  input  logic [TAPS*PIX_W-1:0]  kernel_in,
  output logic                   kernel_ready,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TAPS*PIX_W-1:0]  window_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       result,
  output logic [15:0]            done_count
);
  if (ACC_W < ACC_W_MIN) begin : g_bad_acc_w
    $error("ACC_W must be at least %0d", ACC_W_MIN);
  end
  state_t               state, state_nxt;
  logic [1:0]           select, select_nxt;
  logic [PIX_W-1:0]     window [TAPS];
  logic [PIX_W-1:0]     kernel [TAPS];
  logic [ACC_W-1:0]     acc;
  logic [COL_SUM_W-1:0] sum16;
  logic                 accept, in_col;
  assign kernel_ready = state == IDLE;
  assign in_ready     = (state == IDLE) && rst_n;
  assign out_valid    = state == DONE;
  assign accept       = in_valid && in_ready;
  assign in_col       = (state == COL0) || (state == COL1) || (state == COL2);
  always_comb begin
    state_nxt  = state;
    state_nxt  = (state == IDLE) ? (accept ? COL0 : IDLE) :
                 (state == COL0) ? COL1 :
                 (state == COL1) ? COL2 :
                 (state == COL2) ? DONE :
                 (out_ready ? IDLE : DONE);
    select_nxt = (state_nxt == COL1) ? 2'd1 : (state_nxt == COL2) ? 2'd2 : 2'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      select     <= '0;
      acc        <= '0;
      result     <= '0;
      done_count <= '0;
      window     <= '{default: '0};
      kernel     <= '{default: '0};
    end else begin
      state  <= state_nxt;
      select <= select_nxt;
      if (kernel_load && kernel_ready)
        for (int i = 0; i < TAPS; i++) kernel[i] <= kernel_in[PIX_W*i +: PIX_W];
      if (accept) begin
        for (int i = 0; i < TAPS; i++) window[i] <= window_in[PIX_W*i +: PIX_W];
        acc <= '0;
      end else if (in_col) begin
        acc <= acc + ACC_W'(sum16);
      end
      if (state == COL2) result <= acc + ACC_W'(sum16);
      if (out_valid && out_ready) done_count <= done_count + 16'd1;
    end
  end
  comp u_comp (
    .select (select),
    .img    (window),
    .kern   (kernel),
    .sum16  (sum16)
  );
endmodule

// File: tb/tb_conv3x3_sequencer.sv
// tb_conv3x3_sequencer: directed and randomized self-checking bench against a column-sum reference model
module tb_conv3x3_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        kernel_load = 1'b0;
  logic [71:0] kernel_in = '0;
  logic        kernel_ready;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [71:0] window_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [17:0] result;
  logic [15:0] done_count;
  int          vectors = 0;
  int          miscompares = 0;
  logic [71:0] mk = '0;
  int          dc = 0;
  always #5 clk = ~clk;
  conv3x3_sequencer #(.ACC_W(18)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .kernel_load  (kernel_load),
    .kernel_in    (kernel_in),
    .kernel_ready (kernel_ready),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .window_in    (window_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .done_count   (done_count)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic logic [71:0] bytes9(input int start, input int step);
    logic [71:0] v;
    for (int i = 0; i < 9; i++) v[8*i +: 8] = 8'(start + step * i);
    return v;
  endfunction
  function automatic int ref_result(input logic [71:0] w, input logic [71:0] k);
    int total = 0;
    for (int c = 0; c < 3; c++) begin
      int s = 0;
      for (int r = 0; r < 3; r++) s += int'(w[8*(3*r+c) +: 8]) * int'(k[8*(3*r+c) +: 8]);
      total += s % 65536;
    end
    return total;
  endfunction
  task automatic load_kernel(input logic [71:0] k);
    chk("kernel_ready", 32'(kernel_ready), 1);
    kernel_load = 1'b1;
    kernel_in   = k;
    tick;
    kernel_load = 1'b0;
    mk = k;
  endtask
  task automatic send(input logic [71:0] w, input bit load, input logic [71:0] k,
                      input int hold, input bit pulse_k);
    int exp;
    int cyc;
    chk("in_ready_idle", 32'(in_ready), 1);
    in_valid    = 1'b1;
    window_in   = w;
    kernel_load = load;
    kernel_in   = k;
    if (load) mk = k;
    exp = ref_result(w, mk);
    tick;
    in_valid    = 1'b0;
    kernel_load = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 12) begin
      chk("in_ready_busy", 32'(in_ready), 0);
      tick;
      cyc++;
    end
    chk("latency", cyc, 4);
    chk("result", 32'(result), exp);
    for (int h = 0; h < hold; h++) begin
      if (pulse_k && h == 0) begin
        kernel_load = 1'b1;
        kernel_in   = ~mk;
      end
      tick;
      kernel_load = 1'b0;
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_result", 32'(result), exp);
      chk("hold_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    dc = (dc + 1) % 65536;
    chk("done_count", 32'(done_count), dc);
    chk("valid_drop", 32'(out_valid), 0);
    chk("result_kept", 32'(result), exp);
  endtask
  initial begin
    logic [71:0] k;
    logic [71:0] w;
    tick;
    tick;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_done_count", 32'(done_count), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_kernel_ready", 32'(kernel_ready), 1);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 1);
    load_kernel(bytes9(1, 0));
    send(bytes9(1, 1), 1'b0, '0, 0, 1'b0);
    chk("sum_check", 32'(result), 45);
    k = '0;
    k[32 +: 8] = 8'd1;
    load_kernel(k);
    send(bytes9(10, 10), 1'b0, '0, 0, 1'b0);
    chk("centre_tap", 32'(result), 50);
    load_kernel(bytes9(255, 0));
    send(bytes9(255, 0), 1'b0, '0, 0, 1'b0);
    chk("truncation", 32'(result), 192009);
    load_kernel(bytes9(3, 1));
    send(bytes9(7, 2), 1'b0, '0, 10, 1'b1);
    send(bytes9(1, 1), 1'b0, '0, 0, 1'b0);
    chk("old_kernel_kept", 32'(result), ref_result(bytes9(1, 1), bytes9(3, 1)));
    in_valid  = 1'b1;
    window_in = bytes9(5, 3);
    tick;
    in_valid = 1'b0;
    tick;
    rst_n = 1'b0;
    tick;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_result", 32'(result), 0);
    chk("midrst_done_count", 32'(done_count), 0);
    chk("midrst_idle", 32'(kernel_ready), 1);
    chk("midrst_in_ready", 32'(in_ready), 0);
    mk = '0;
    dc = 0;
    rst_n = 1'b1;
    #1;
    chk("midrst_release", 32'(in_ready), 1);
    tick;
    chk("midrst_still_idle", 32'(out_valid), 0);
    load_kernel(bytes9(9, 7));
    send(bytes9(4, 11), 1'b0, '0, 1, 1'b0);
    send(bytes9(1, 0), 1'b1, bytes9(2, 0), 0, 1'b0);
    chk("same_cycle_load", 32'(result), 18);
    for (int n = 0; n < 40; n++) begin
      k = 72'({$urandom(), $urandom(), $urandom()});
      w = 72'({$urandom(), $urandom(), $urandom()});
      if ($urandom_range(0, 3) == 0) load_kernel(k);
      send(w, $urandom_range(0, 2) == 0, ~k, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) tick;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/conv3x3_sequencer.md
# conv3x3_sequencer

Sequencing controller for the 3x3 column-multiplexed MAC datapath (`comp`). It latches one kernel and one 3x3 image window, steps the datapath's column `select` through 0, 1, 2, and accumulates the three 16-bit column sums into one full-width convolution result. Results go out on a valid/ready handshake. It sits between the line-buffer/window generator upstream and the activation/output stage downstream.

## Interface
Parameters:
- `ACC_W`, default 18: width of the accumulator and result. Must be ≥ 18; values below 18 are illegal.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `kernel_load`  in  1: write `kernel_in` into the kernel registers. Honoured only in IDLE.
- `kernel_in`  in  72: nine unsigned bytes. Byte i is bits [8i+7:8i], row-major, i = 3·row + col.
- `kernel_ready`  out  1: high exactly when state is IDLE.
- `in_valid`  in  1: the window on `window_in` is valid.
- `in_ready`  out  1: high exactly when state is IDLE and `rst_n` is high.
- `window_in`  in  72: nine unsigned image bytes, same packing as `kernel_in`.
- `out_valid`  out  1: `result` is valid.
- `out_ready`  in  1: downstream accepts `result`.
- `result`  out  ACC_W: accumulated sum of the three column sums, zero-extended.
- `done_count`  out  16: number of results accepted downstream, wraps at 2^16.

## Operation
- State machine:
  - IDLE → COL0 on `in_valid && in_ready`.
  - COL0 → COL1 → COL2 → DONE unconditionally.
  - DONE → IDLE when `out_ready` is high.
- On accept:
  - Latch `window_in` into the window registers.
  - Clear the accumulator.
- Datapath drive:
  - `select` = 0, 1, 2 in COL0, COL1, COL2 respectively.
  - `select` = 0 in IDLE and DONE.
  - `select` = 3 is never driven.
- Datapath row/column mapping: for row r (0..2), the datapath's image/kernel triplet r is bytes 3r, 3r+1, 3r+2. `select` = c therefore yields Σ_r img[3r+c]·k[3r+c].
- Accumulation: in each COLx state, acc ← acc + zero-extend(sum16).
  - sum16 is the datapath's 16-bit column sum and is already taken modulo 2^16. The sequencer does not correct this truncation.
  - The accumulator never overflows, because 3·(2^16−1) < 2^18.
- `result` is registered.
  - It loads the final accumulator value on COL2 → DONE.
  - It holds stable until the next COL2 → DONE.
- `out_valid` is high exactly in DONE.
- `done_count` increments on each `out_valid && out_ready`.
- Kernel load:
  - The kernel registers update on `kernel_load && kernel_ready`.
  - `kernel_load` outside IDLE is ignored; it is dropped, not queued.
  - If `kernel_load` and a window accept happen in the same IDLE cycle, both registers update on that edge, and the accepted window is computed with the new kernel.
- The kernel persists across any number of windows until it is reloaded.

## Timing
- Window accepted at edge T:
  - COL0, COL1, COL2 occupy cycles T+1, T+2, T+3.
  - `out_valid` rises at T+4.
- Latency from accept to `out_valid` is 4 cycles.
- Peak throughput is one window per 5 cycles: a new accept is possible in the first IDLE cycle after the DONE handshake.
- Back-to-back windows are not accepted while DONE waits on `out_ready`; `in_ready` stays low.
- Datapath path: `select` and the window/kernel registers are stable for the whole cycle, and the combinational sum16 is captured at the end of that same cycle. There is no extra pipeline stage.
- Reset (`rst_n` low at a clock edge), including mid-operation:
  - state = IDLE, `out_valid` = 0, `result` = 0, accumulator = 0.
  - Window and kernel registers = 0, `done_count` = 0.
  - An in-flight window is discarded.
  - `in_ready` is low while `rst_n` is low and high in the first cycle after release.

## Structure
- Shared package `conv_pkg` holds:
  - the state enum {IDLE, COL0, COL1, COL2, DONE};
  - constants `PIX_W = 8`, `TAPS = 9`, `COL_SUM_W = 16`, `ACC_W_MIN = 18`.
- Sub-module: exactly one instance of `comp`, with its ports wired from the unpacked window/kernel registers and the registered `select`.
- All remaining logic stays flat in the sequencer.

## Test plan
- Sum check: load kernel of all 1s, send window bytes 1..9 → `result` = 45, `out_valid` at accept+4, `done_count` = 1.
- Centre-tap check: load kernel with only byte 4 = 1, send window 10,20,…,90 → `result` = 50. This also checks that `select` visits 0, 1, 2 in order.
- Truncation check: kernel and window all 255 → each column sum = 64003 (195075 mod 2^16) → `result` = 192009.
- Backpressure: hold `out_ready` low for 10 cycles in DONE.
  - `result` and `out_valid` stay stable and `in_ready` stays 0.
  - A `kernel_load` pulse during the wait is ignored; a following window still uses the old kernel.
- Reset mid-operation: drop `rst_n` in COL1.
  - Next cycle: IDLE, `out_valid` = 0, `result` = 0.
  - After release, a fresh window computes correctly from a reloaded kernel.
- Same-cycle load and accept: in one IDLE cycle, `kernel_load` with all 2s plus a window of all 1s → `result` = 18.
